// File: rtl/gci_std_kmc_pkg.sv
// -----------------------------------------------------------------------------
// gci_std_kmc_pkg
// Shared definitions for the keyboard-matrix controller event path.
//   KMC_N / KMC_KW : default key-line count and matching key-code width
//   kmc_event_t    : one queued key event (key index + press/release flag)
//   EV_PRESS       : value of the press flag for a key going down
//   EV_RELEASE     : value of the press flag for a key going up
// -----------------------------------------------------------------------------
package gci_std_kmc_pkg;

  localparam int KMC_N  = 16;
  localparam int KMC_KW = $clog2(KMC_N);

  localparam logic EV_PRESS   = 1'b1;
  localparam logic EV_RELEASE = 1'b0;

  typedef struct packed {
    logic [KMC_KW-1:0] code;
    logic              press;
  } kmc_event_t;

endpackage : gci_std_kmc_pkg

// File: rtl/gci_std_kmc_event_fifo.sv
// -----------------------------------------------------------------------------
// gci_std_kmc_event_fifo
// Synchronous first-word-fall-through FIFO. The head entry is driven
// combinationally from storage at the read pointer.
// Ports:
//   iCLOCK   : clock
//   inRESET  : synchronous active-low reset (clears pointers and storage)
//   iWR_EN   : push request; ignored while full
//   iWR_DATA : data to push
//   iRD_EN   : pop request; ignored while empty
//   oRD_DATA : head entry
//   oEMPTY   : no entries queued
//   oFULL    : DEPTH entries queued
//   oCOUNT   : number of queued entries
// -----------------------------------------------------------------------------
module gci_std_kmc_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8
) (
  input  logic                       iCLOCK,
  input  logic                       inRESET,
  input  logic                       iWR_EN,
  input  logic [W-1:0]               iWR_DATA,
  input  logic                       iRD_EN,
  output logic [W-1:0]               oRD_DATA,
  output logic                       oEMPTY,
  output logic                       oFULL,
  output logic [$clog2(DEPTH):0]     oCOUNT
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit that toggles on each wrap, so equal
  // pointers mean empty and equal-low/different-wrap means full.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign oEMPTY   = (r_wr_ptr == r_rd_ptr);
  assign oFULL    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign oCOUNT   = r_wr_ptr - r_rd_ptr;
  assign oRD_DATA = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = iWR_EN && !oFULL;
  assign w_pop  = iRD_EN && !oEMPTY;

  // NOTE: storage is reset on purpose so the head outputs read as zero after
  // reset; this costs a reset net per flop but keeps the host view clean.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= iWR_DATA;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule : gci_std_kmc_event_fifo

// File: rtl/gci_std_kmc_key_event.sv
// -----------------------------------------------------------------------------
// gci_std_kmc_key_event
// Turns changes of the debounced key vector into press/release events,
// one per cycle in ascending key order, queued in an FWFT FIFO. Detection
// stalls rather than dropping a transition while the FIFO is full.
// Ports:
//   iCLOCK       : 50 MHz system clock
//   inRESET      : synchronous active-low reset
//   iKEY         : debounced key lines, 1 = pressed
//   oEVENT_VALID : head event valid
//   oEVENT_CODE  : key index of head event
//   oEVENT_PRESS : 1 = press, 0 = release
//   iEVENT_READY : consumer takes head event this cycle
//   oFULL        : FIFO holds DEPTH entries
//   oCOUNT       : queued entry count
//   oSTALL       : a change is pending but the FIFO is full
// -----------------------------------------------------------------------------
module gci_std_kmc_key_event
  import gci_std_kmc_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int KW    = $clog2(N)
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic [N-1:0]           iKEY,
  output logic                   oEVENT_VALID,
  output logic [KW-1:0]          oEVENT_CODE,
  output logic                   oEVENT_PRESS,
  input  logic                   iEVENT_READY,
  output logic                   oFULL,
  output logic [$clog2(DEPTH):0] oCOUNT,
  output logic                   oSTALL
);

  logic [N-1:0]  r_rep;       // last reported state per key
  logic [N-1:0]  w_pend;
  logic          w_any;
  logic [KW-1:0] w_sel;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic [KW:0]   w_wr_data;
  logic [KW:0]   w_rd_data;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_pend = iKEY ^ r_rep;
    w_any  = |w_pend;
    w_sel  = '0;
    // Scanning high to low lets the lowest set index win the last write.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_sel = KW'(i);
      end
    end
  end

  // Space is judged from the count at the start of the cycle: a pop in the
  // same cycle does not make room for a push until the next edge.
  assign w_push    = w_any && !w_full;
  assign w_wr_data = {w_sel, iKEY[w_sel]};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      r_rep <= '0;
    end else if (w_push) begin
      r_rep[w_sel] <= iKEY[w_sel];
    end
  end

  gci_std_kmc_event_fifo #(
    .W     (KW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .iWR_EN   (w_push),
    .iWR_DATA (w_wr_data),
    .iRD_EN   (iEVENT_READY),
    .oRD_DATA (w_rd_data),
    .oEMPTY   (w_empty),
    .oFULL    (w_full),
    .oCOUNT   (oCOUNT)
  );

  assign oEVENT_VALID = !w_empty;
  assign oEVENT_CODE  = w_rd_data[KW:1];
  assign oEVENT_PRESS = (w_rd_data[0] == EV_PRESS);
  assign oFULL        = w_full;
  assign oSTALL       = w_any && w_full;

endmodule : gci_std_kmc_key_event

// File: tb/tb_gci_std_kmc_key_event.sv
// -----------------------------------------------------------------------------
// tb_gci_std_kmc_key_event
// Directed bench for the key event encoder (N = 16, DEPTH = 8). Inputs are
// changed and outputs observed 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_gci_std_kmc_key_event;
  import gci_std_kmc_pkg::*;

  localparam int N     = 16;
  localparam int DEPTH = 8;
  localparam int KW    = $clog2(N);

  logic                   iCLOCK = 1'b0;
  logic                   inRESET;
  logic [N-1:0]           iKEY;
  logic                   oEVENT_VALID;
  logic [KW-1:0]          oEVENT_CODE;
  logic                   oEVENT_PRESS;
  logic                   iEVENT_READY;
  logic                   oFULL;
  logic [$clog2(DEPTH):0] oCOUNT;
  logic                   oSTALL;

  int n_cmp = 0;
  int n_err = 0;

  gci_std_kmc_key_event #(.N(N), .DEPTH(DEPTH)) dut (
    .iCLOCK       (iCLOCK),
    .inRESET      (inRESET),
    .iKEY         (iKEY),
    .oEVENT_VALID (oEVENT_VALID),
    .oEVENT_CODE  (oEVENT_CODE),
    .oEVENT_PRESS (oEVENT_PRESS),
    .iEVENT_READY (iEVENT_READY),
    .oFULL        (oFULL),
    .oCOUNT       (oCOUNT),
    .oSTALL       (oSTALL)
  );

  always #10 iCLOCK = ~iCLOCK;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge iCLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input int code, input logic press);
    kmc_event_t ev;
    ev.code  = KMC_KW'(code);
    ev.press = press;
    check({tag, " valid"}, 32'(oEVENT_VALID), 32'd1);
    check({tag, " event"}, 32'({oEVENT_CODE, oEVENT_PRESS}), 32'(ev));
  endtask

  initial begin
    inRESET      = 1'b0;
    iKEY         = '0;
    iEVENT_READY = 1'b0;
    tick(2);
    check("rst valid", 32'(oEVENT_VALID), 32'd0);
    check("rst count", 32'(oCOUNT), 32'd0);
    check("rst full",  32'(oFULL), 32'd0);
    check("rst stall", 32'(oSTALL), 32'd0);
    check("rst code",  32'(oEVENT_CODE), 32'd0);
    check("rst press", 32'(oEVENT_PRESS), 32'd0);

    // Idle: no key changes, nothing queued.
    inRESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle valid", 32'(oEVENT_VALID), 32'd0);
    end
    check("idle count", 32'(oCOUNT), 32'd0);

    // Single press then release of key 5, consumer always ready.
    iEVENT_READY = 1'b1;
    iKEY         = 16'h0020;
    tick();
    check_head("k5 press", 5, EV_PRESS);
    check("k5 count", 32'(oCOUNT), 32'd1);
    iKEY = 16'h0000;
    tick();                           // pop press, push release together
    check_head("k5 release", 5, EV_RELEASE);
    check("k5 count2", 32'(oCOUNT), 32'd1);
    tick();
    check("k5 drained", 32'(oEVENT_VALID), 32'd0);
    check("k5 count0", 32'(oCOUNT), 32'd0);

    // Four simultaneous presses, ascending order, one push per edge.
    iEVENT_READY = 1'b0;
    iKEY         = 16'h8103;
    tick();
    check("multi c1", 32'(oCOUNT), 32'd1);
    check_head("multi head", 0, EV_PRESS);
    tick();
    check("multi c2", 32'(oCOUNT), 32'd2);
    tick();
    check("multi c3", 32'(oCOUNT), 32'd3);
    tick();
    check("multi c4", 32'(oCOUNT), 32'd4);
    check("multi stall", 32'(oSTALL), 32'd0);
    tick();
    check("multi c4 hold", 32'(oCOUNT), 32'd4);
    iEVENT_READY = 1'b1;
    check_head("multi e0", 0, EV_PRESS);
    tick();
    check_head("multi e1", 1, EV_PRESS);
    tick();
    check_head("multi e8", 8, EV_PRESS);
    tick();
    check_head("multi e15", 15, EV_PRESS);
    tick();
    check("multi empty", 32'(oEVENT_VALID), 32'd0);
    iKEY = 16'h0000;                  // four releases pushed and popped
    tick(10);
    check("rel count0", 32'(oCOUNT), 32'd0);
    check("rel valid0", 32'(oEVENT_VALID), 32'd0);

    // Overflow: ten presses into an eight-deep FIFO.
    iEVENT_READY = 1'b0;
    iKEY         = 16'h03FF;
    tick(7);
    check("ovf c7", 32'(oCOUNT), 32'd7);
    check("ovf nfull", 32'(oFULL), 32'd0);
    tick();
    check("ovf c8", 32'(oCOUNT), 32'd8);
    check("ovf full", 32'(oFULL), 32'd1);
    check("ovf stall", 32'(oSTALL), 32'd1);
    check_head("ovf head", 0, EV_PRESS);
    iEVENT_READY = 1'b1;
    tick();                           // pop only, no push while full
    check("ovf pop c7", 32'(oCOUNT), 32'd7);
    check("ovf pop stall", 32'(oSTALL), 32'd0);
    iEVENT_READY = 1'b0;
    tick();                           // stalled code 8 enters
    check("ovf refill c8", 32'(oCOUNT), 32'd8);
    check("ovf refill stall", 32'(oSTALL), 32'd1);
    iEVENT_READY = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      check_head("ovf drain", c, EV_PRESS);
      tick();
    end
    check("ovf done valid", 32'(oEVENT_VALID), 32'd0);
    check("ovf done count", 32'(oCOUNT), 32'd0);
    check("ovf done stall", 32'(oSTALL), 32'd0);

    // Reset with three releases queued; held keys re-reported afterwards.
    iEVENT_READY = 1'b0;
    iKEY         = 16'h03F8;
    tick(3);
    check("mid c3", 32'(oCOUNT), 32'd3);
    inRESET = 1'b0;
    tick();
    check("mid rst valid", 32'(oEVENT_VALID), 32'd0);
    check("mid rst count", 32'(oCOUNT), 32'd0);
    check("mid rst stall", 32'(oSTALL), 32'd0);
    check("mid rst code", 32'(oEVENT_CODE), 32'd0);
    inRESET = 1'b1;
    tick(7);
    check("re c7", 32'(oCOUNT), 32'd7);
    check("re stall", 32'(oSTALL), 32'd0);
    iEVENT_READY = 1'b1;
    for (int c = 3; c <= 9; c++) begin
      check_head("re drain", c, EV_PRESS);
      tick();
    end
    check("re done valid", 32'(oEVENT_VALID), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_gci_std_kmc_key_event
